// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: arms the receive chain, counts demapped bytes,
// forwards them to the MAC through a one-entry registered stage tagged with
// SOF/EOF, and closes the frame on completion, watchdog timeout or abort.
module rx_frame_ctrl #(
    parameter int unsigned BYTES_PER_SYM = 48,
    parameter int unsigned TOUT_CYC      = 4096,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] NSYM_I,
    input  logic [3:0] SNR_I,
    output logic       RX_EN,
    output logic [3:0] SNR_O,
    input  logic [7:0] DAT_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    input  logic       ACK_I,
    output logic       SOF_O,
    output logic       EOF_O,
    output logic       BUSY,
    output logic       DONE,
    output logic       TOUT
);

    typedef enum logic [2:0] {
        sIdle,
        sArm,
        sRun,
        sDrain,
        sErr
    } frameStateT;

    frameStateT       state;
    frameStateT       stateNext;
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] byteCnt;
    logic [CNT_W-1:0] wdCnt;
    logic [3:0]       snrQ;
    logic [7:0]       outDat;
    logic             outStb;
    logic             outSof;
    logic             outEof;
    logic             doneQ;
    logic             active;
    logic             inXfer;
    logic             outXfer;
    logic             isLast;
    logic             wdExpire;

    // The demapper strobes carry no information beyond STB_I for this stream.
    logic unusedIn;
    assign unusedIn = ^{CYC_I, WE_I};

    // State register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and state-derived outputs; ACK_O passes ACK_I through
    // combinationally so the output stage can refill on the cycle it empties.
    always_comb begin
        stateNext = state;
        active    = (state == sArm) || (state == sRun);
        ACK_O     = active && (!outStb || ACK_I);
        inXfer    = STB_I && ACK_O;
        outXfer   = outStb && ACK_I;
        isLast    = (byteCnt == tot - CNT_W'(1));
        wdExpire  = active && !inXfer && (wdCnt == CNT_W'(TOUT_CYC - 1));
        RX_EN     = active;
        BUSY      = (state != sIdle);
        CYC_O     = (state != sIdle);
        TOUT      = (state == sErr);
        case (state)
            sIdle: begin
                if (START && (NSYM_I != '0)) begin
                    stateNext = sArm;
                end
            end
            sArm, sRun: begin
                if (ABORT || wdExpire) begin
                    stateNext = sErr;
                end else if (inXfer) begin
                    stateNext = isLast ? sDrain : sRun;
                end
            end
            sDrain: begin
                if (ABORT) begin
                    stateNext = sErr;
                end else if (outXfer) begin
                    stateNext = sIdle;
                end
            end
            sErr: begin
                stateNext = sIdle;
            end
            default: begin
                stateNext = sIdle;
            end
        endcase
    end

    // Frame parameters, counters, completion pulse and the output stage.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            tot     <= '0;
            byteCnt <= '0;
            wdCnt   <= '0;
            snrQ    <= '0;
            outDat  <= '0;
            outStb  <= 1'b0;
            outSof  <= 1'b0;
            outEof  <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if ((state == sIdle) && START) begin
                if (NSYM_I == '0) begin
                    doneQ <= 1'b1;
                end else begin
                    tot  <= CNT_W'(NSYM_I) * CNT_W'(BYTES_PER_SYM);
                    snrQ <= SNR_I;
                end
            end
            if ((state == sDrain) && (stateNext == sIdle)) begin
                doneQ <= 1'b1;
            end

            if (state == sIdle) begin
                byteCnt <= '0;
            end else if (inXfer) begin
                byteCnt <= byteCnt + CNT_W'(1);
            end

            // Outside ARM/RUN the count rests at zero, which also covers the
            // clear on entry to ARM.
            if (active && !inXfer) begin
                wdCnt <= wdCnt + CNT_W'(1);
            end else begin
                wdCnt <= '0;
            end

            if ((stateNext == sErr) || (state == sErr)) begin
                outStb <= 1'b0;
                outSof <= 1'b0;
                outEof <= 1'b0;
            end else if (inXfer) begin
                outDat <= DAT_I;
                outStb <= 1'b1;
                outSof <= (state == sArm);
                outEof <= isLast;
            end else if (outXfer) begin
                outStb <= 1'b0;
                outSof <= 1'b0;
                outEof <= 1'b0;
            end
        end
    end

    assign SNR_O = snrQ;
    assign DAT_O = outDat;
    assign STB_O = outStb;
    assign WE_O  = outStb;
    assign SOF_O = outSof;
    assign EOF_O = outEof;
    assign DONE  = doneQ;

endmodule
